mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_array.sv | 34 +++
 rtl/mem_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the line-burst memory controller.
package mem_pkg;

    localparam int unsigned AWIDTH_DEF    = 9;
    localparam int unsigned DWIDTH_DEF    = 8;
    localparam int unsigned BLOCKSIZE_DEF = 4;
    localparam int unsigned LATENCY_DEF   = 3;

    localparam logic [3:0] BEAT_IDLE = 4'd0;
    localparam logic [3:0] BEAT1     = 4'd1;
    localparam logic [3:0] BEAT2     = 4'd2;
    localparam logic [3:0] BEAT3     = 4'd3;
    localparam logic [3:0] BEAT4     = 4'd4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_WAIT   = 3'd1,
        RD_BURST  = 3'd2,
        WR_BURST  = 3'd3,
        WR_COMMIT = 3'd4
    } state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port byte array: synchronous write, synchronous read with a held read register.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned AWIDTH = AWIDTH_DEF,
    parameter int unsigned DWIDTH = DWIDTH_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [AWIDTH-1:0] addr,
    input  logic              we,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [2**AWIDTH];

    // Storage is deliberately not reset so contents survive a controller reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Line-burst controller: beat-indexed read/write bursts onto a single-port array.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned AWIDTH    = AWIDTH_DEF,
    parameter int unsigned DWIDTH    = DWIDTH_DEF,
    parameter int unsigned BLOCKSIZE = BLOCKSIZE_DEF,
    parameter int unsigned LATENCY   = LATENCY_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [AWIDTH-1:0] addr_mem,
    input  logic [3:0]        rd_mem,
    input  logic [3:0]        wr_mem,
    input  logic [DWIDTH-1:0] wmem_byte,
    output logic [DWIDTH-1:0] rdata_mem,
    output logic              rvalid_mem,
    output logic              ready_mem,
    output logic              proto_err
);

    localparam logic [3:0] LAT4     = 4'(LATENCY);
    localparam logic [1:0] LAST_OFS = 2'(BLOCKSIZE - 1);

    state_t            state;
    logic [AWIDTH-3:0] line_q;
    logic [1:0]        offset_q;
    logic [3:0]        cnt_q;

    logic              rd_start, wr_start, beat_hit;
    logic [AWIDTH-1:0] arr_addr;
    logic              arr_we, arr_re;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^addr_mem[1:0];
    assign rd_start  = (rd_mem == BEAT1) && (wr_mem == BEAT_IDLE);
    assign wr_start  = (wr_mem == BEAT1) && (rd_mem == BEAT_IDLE);
    // offset_q holds the index of the next byte, so the expected beat is offset_q + 1.
    assign beat_hit  = (wr_mem == ({2'b00, offset_q} + 4'd1));
    assign ready_mem = (state == IDLE);

    always_comb begin
        arr_addr = {line_q, offset_q};
        arr_we   = 1'b0;
        arr_re   = (state == RD_BURST);
        if (state == IDLE) begin
            arr_addr = {addr_mem[AWIDTH-1:2], 2'b00};
            arr_we   = wr_start;
        end else if (state == WR_BURST) begin
            arr_we = beat_hit;
        end
        // A beat coinciding with reset is aborted, not written.
        if (reset) begin
            arr_we = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            line_q     <= '0;
            offset_q   <= '0;
            cnt_q      <= '0;
            rvalid_mem <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            rvalid_mem <= (state == RD_BURST);
            unique case (state)
                IDLE: begin
                    offset_q <= '0;
                    if (rd_start) begin
                        line_q <= addr_mem[AWIDTH-1:2];
                        cnt_q  <= LAT4;
                        state  <= RD_WAIT;
                    end else if (wr_start) begin
                        line_q   <= addr_mem[AWIDTH-1:2];
                        offset_q <= 2'd1;
                        state    <= WR_BURST;
                    end else if (rd_mem != BEAT_IDLE || wr_mem != BEAT_IDLE) begin
                        proto_err <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    offset_q <= offset_q + 2'd1;
                    if (offset_q == LAST_OFS) begin
                        state <= IDLE;
                    end
                end
                WR_BURST: begin
                    if (beat_hit) begin
                        offset_q <= offset_q + 2'd1;
                        if (offset_q == LAST_OFS) begin
                            cnt_q <= LAT4;
                            state <= WR_COMMIT;
                        end
                    end else if (wr_mem != BEAT_IDLE) begin
                        proto_err <= 1'b1;
                    end
                end
                WR_COMMIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_array #(
        .AWIDTH(AWIDTH),
        .DWIDTH(DWIDTH)
    ) u_array (
        .clock(clock),
        .reset(reset),
        .addr (arr_addr),
        .we   (arr_we),
        .wdata(wmem_byte),
        .re   (arr_re),
        .rdata(rdata_mem)
    );

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed corner cases, error-vector table, random bursts.
module tb_mem_ctrl;

    localparam int LAT = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic [8:0] addr_mem;
    logic [3:0] rd_mem, wr_mem;
    logic [7:0] wmem_byte, rdata_mem;
    logic       rvalid_mem, ready_mem, proto_err;

    logic       reset1;
    logic [8:0] addr1;
    logic [3:0] rd1, wr1;
    logic [7:0] wb1, rdata1;
    logic       rvalid1, ready1, perr1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model_mem [512];
    bit         model_ok  [512];

    typedef struct {
        logic [3:0] rd;
        logic [3:0] wr;
        logic       exp_err;
    } err_vec_t;
    err_vec_t vecs [8];

    always #5 clock = ~clock;

    mem_ctrl #(.AWIDTH(9), .DWIDTH(8), .BLOCKSIZE(4), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset), .addr_mem(addr_mem), .rd_mem(rd_mem), .wr_mem(wr_mem),
        .wmem_byte(wmem_byte), .rdata_mem(rdata_mem), .rvalid_mem(rvalid_mem),
        .ready_mem(ready_mem), .proto_err(proto_err)
    );

    mem_ctrl #(.AWIDTH(9), .DWIDTH(8), .BLOCKSIZE(4), .LATENCY(1)) dut1 (
        .clock(clock), .reset(reset1), .addr_mem(addr1), .rd_mem(rd1), .wr_mem(wr1),
        .wmem_byte(wb1), .rdata_mem(rdata1), .rvalid_mem(rvalid1),
        .ready_mem(ready1), .proto_err(perr1)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        rd_mem = 4'd0;
        wr_mem = 4'd0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready_mem && n < 50) begin
            step();
            n++;
        end
        check("ready_timeout", 32'(ready_mem), 32'd1);
    endtask

    task automatic model_write(input logic [8:0] a, input int ofs, input logic [7:0] v);
        int idx = int'({a[8:2], 2'b00}) + ofs;
        model_mem[idx] = v;
        model_ok[idx]  = 1'b1;
    endtask

    task automatic write_line(input logic [8:0] a, input logic [31:0] d, input int stall2,
                              input bit rstall, input bit bad);
        int n;
        int stalls;
        wait_ready();
        addr_mem  = a;
        rd_mem    = 4'd0;
        wr_mem    = 4'd1;
        wmem_byte = d[7:0];
        step();
        model_write(a, 0, d[7:0]);
        check("wr_busy", 32'(ready_mem), 32'd0);
        for (int k = 2; k <= 4; k++) begin
            stalls = ((k == 3) ? stall2 : 0) + (rstall ? int'($urandom_range(0, 2)) : 0);
            for (int s = 0; s < stalls; s++) begin
                wr_mem    = 4'd0;
                wmem_byte = 8'($urandom);
                step();
            end
            if (bad && k == 3) begin
                wr_mem    = 4'd1;
                wmem_byte = 8'($urandom);
                step();
            end
            wr_mem    = 4'(k);
            wmem_byte = d[8*(k-1) +: 8];
            step();
            model_write(a, k - 1, d[8*(k-1) +: 8]);
        end
        wr_mem = 4'd0;
        n = 0;
        while (!ready_mem && n < 40) begin
            step();
            n++;
        end
        check("wr_commit_cycles", 32'(n), 32'(LAT));
    endtask

    task automatic read_line(input logic [8:0] a, input bit garbage);
        int n;
        int base;
        logic [7:0] last;
        base = int'({a[8:2], 2'b00});
        wait_ready();
        addr_mem = a;
        rd_mem   = 4'd1;
        wr_mem   = 4'd0;
        step();
        rd_mem = garbage ? 4'($urandom_range(0, 15)) : 4'd0;
        check("rd_busy", 32'(ready_mem), 32'd0);
        n = 0;
        while (!rvalid_mem && n < 40) begin
            step();
            n++;
            if (garbage) rd_mem = 4'($urandom_range(0, 15));
        end
        check("rd_latency", 32'(n), 32'(LAT + 1));
        last = rdata_mem;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            rd_mem = (garbage && i < 3) ? 4'($urandom_range(0, 15)) : 4'd0;
            check("rd_valid", 32'(rvalid_mem), 32'd1);
            if (model_ok[base + i]) check("rd_data", 32'(rdata_mem), 32'(model_mem[base + i]));
            last = rdata_mem;
        end
        step();
        check("rd_valid_end", 32'(rvalid_mem), 32'd0);
        check("rd_hold", 32'(rdata_mem), 32'(last));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 512; i++) model_ok[i] = 1'b0;
        vecs[0] = '{rd: 4'd1,  wr: 4'd1, exp_err: 1'b1};
        vecs[1] = '{rd: 4'd2,  wr: 4'd0, exp_err: 1'b1};
        vecs[2] = '{rd: 4'd0,  wr: 4'd3, exp_err: 1'b1};
        vecs[3] = '{rd: 4'd0,  wr: 4'd0, exp_err: 1'b0};
        vecs[4] = '{rd: 4'd4,  wr: 4'd4, exp_err: 1'b1};
        vecs[5] = '{rd: 4'd15, wr: 4'd0, exp_err: 1'b1};
        vecs[6] = '{rd: 4'd0,  wr: 4'd2, exp_err: 1'b1};
        vecs[7] = '{rd: 4'd1,  wr: 4'd2, exp_err: 1'b1};

        addr_mem = '0; wmem_byte = '0; rd_mem = '0; wr_mem = '0;
        addr1 = '0; wb1 = '0; rd1 = '0; wr1 = '0; reset1 = 1'b1;

        // Reset then idle.
        do_reset();
        repeat (5) step();
        check("rst_ready", 32'(ready_mem), 32'd1);
        check("rst_rvalid", 32'(rvalid_mem), 32'd0);
        check("rst_perr", 32'(proto_err), 32'd0);
        check("rst_rdata", 32'(rdata_mem), 32'd0);

        // Basic write then read with unaligned address.
        write_line(9'h0A4, 32'h44332211, 0, 1'b0, 1'b0);
        read_line(9'h0A7, 1'b0);

        // Stall of two cycles between beats 2 and 3.
        write_line(9'h0B0, 32'hDDCCBBAA, 2, 1'b0, 1'b0);
        read_line(9'h0B2, 1'b0);
        check("stall_perr", 32'(proto_err), 32'd0);

        // Illegal beat combinations in IDLE.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            addr_mem  = 9'h0A4;
            wmem_byte = 8'hEE;
            rd_mem    = vecs[v].rd;
            wr_mem    = vecs[v].wr;
            step();
            rd_mem = 4'd0;
            wr_mem = 4'd0;
            step();
            check($sformatf("idle_vec%0d_perr", v), 32'(proto_err), 32'(vecs[v].exp_err));
            check($sformatf("idle_vec%0d_ready", v), 32'(ready_mem), 32'd1);
        end
        do_reset();
        read_line(9'h0A4, 1'b0);

        // Unexpected beat mid-write is flagged and ignored.
        write_line(9'h0C0, 32'h78563412, 0, 1'b0, 1'b1);
        check("badbeat_perr", 32'(proto_err), 32'd1);
        read_line(9'h0C0, 1'b0);
        do_reset();

        // Reset during beat 3 aborts the burst but keeps earlier bytes.
        write_line(9'h1F0, 32'hA4A3A2A1, 0, 1'b0, 1'b0);
        wait_ready();
        addr_mem = 9'h1F0;
        wr_mem = 4'd1; wmem_byte = 8'hB1; step();
        wr_mem = 4'd2; wmem_byte = 8'hB2; step();
        wr_mem = 4'd3; wmem_byte = 8'hB3; reset = 1'b1; step();
        reset = 1'b0;
        wr_mem = 4'd0;
        model_write(9'h1F0, 0, 8'hB1);
        model_write(9'h1F0, 1, 8'hB2);
        check("abort_ready", 32'(ready_mem), 32'd1);
        check("abort_rvalid", 32'(rvalid_mem), 32'd0);
        check("abort_rdata", 32'(rdata_mem), 32'd0);
        read_line(9'h1F0, 1'b0);

        // Random bursts over a small set of lines, rd_mem noise during reads.
        for (int it = 0; it < 40; it++) begin
            logic [8:0] ra;
            ra = 9'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) write_line(ra, $urandom, 0, 1'b1, 1'b0);
            else read_line(ra, 1'b1);
        end
        check("rand_perr", 32'(proto_err), 32'd0);

        // LATENCY=1 instance: back-to-back reads.
        step();
        reset1 = 1'b0;
        addr1  = 9'h040;
        for (int k = 1; k <= 4; k++) begin
            wr1 = 4'(k);
            wb1 = 8'(8'h50 + k);
            step();
        end
        wr1 = 4'd0;
        n = 0;
        while (!ready1 && n < 20) begin step(); n++; end
        check("l1_commit", 32'(n), 32'd1);
        rd1 = 4'd1;
        step();
        rd1 = 4'd0;
        n = 0;
        while (!rvalid1 && n < 20) begin step(); n++; end
        check("l1_latency", 32'(n), 32'd2);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            check("l1_valid", 32'(rvalid1), 32'd1);
            check("l1_data", 32'(rdata1), 32'(8'h51 + i));
        end
        check("l1_ready_at_last", 32'(ready1), 32'd1);
        rd1 = 4'd1;
        step();
        rd1 = 4'd0;
        check("l1_second_accept", 32'(ready1), 32'd0);
        check("l1_gap_rvalid", 32'(rvalid1), 32'd0);
        n = 0;
        while (!rvalid1 && n < 20) begin step(); n++; end
        check("l1_latency2", 32'(n), 32'd2);
        check("l1_data2", 32'(rdata1), 32'h51);
        check("l1_perr", 32'(perr1), 32'd0);
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
